// File: rtl/eth_header_sequencer.sv
// eth_header_sequencer
//   Byte-level sequencer for the Ethernet packet detector datapath. It follows
//   a framed byte stream and walks the header by byte count. It captures the
//   destination MAC, the source MAC and the type/length field, and checks the
//   payload size against the type/length value.
//
//   Ports:
//     clock             rising-edge clock
//     reset             synchronous, active-high reset
//     control           frame valid, one byte per cycle while high
//     data              frame byte, sampled only when control=1
//     dst_mac           captured destination MAC (first byte in [47:40])
//     src_mac           captured source MAC (first byte in [47:40])
//     type_length       captured type/length (first byte in [15:8])
//     type_length_valid one-cycle pulse: type/length complete and legal
//     packet_size_valid one-cycle pulse: payload size check passed
//     frame_error       one-cycle pulse: framing or size violation
//     enable_header     level: header module enable
//     enable_payload    level: payload module enable
//
//   Optional macro ETH_VLAN_EN adds 802.1Q tag handling:
//     vlan_tci          captured tag control info (bytes 14-15)
//     vlan_valid        one-cycle pulse when vlan_tci is complete
module eth_header_sequencer #(
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500,
    parameter int CNT_W       = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        control,
    input  logic [7:0]  data,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] type_length,
    output logic        type_length_valid,
    output logic        packet_size_valid,
    output logic        frame_error,
`ifdef ETH_VLAN_EN
    output logic [15:0] vlan_tci,
    output logic        vlan_valid,
`endif
    output logic        enable_header,
    output logic        enable_payload
);

    typedef enum logic [2:0] {SYNC, IDLE, DST, SRC, TYPE, PAYLOAD, DONE} state_t;

    localparam logic [15:0]      MAX_TL        = 16'(MAX_PAYLOAD);
    localparam logic [15:0]      MIN_TL        = 16'(MIN_PAYLOAD);
    localparam logic [15:0]      ETHERTYPE_MIN = 16'h0600;
    localparam logic [CNT_W-1:0] CNT_MIN       = CNT_W'(MIN_PAYLOAD);
    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(MAX_PAYLOAD);
    localparam logic [CNT_W-1:0] CNT_OVF       = CNT_W'(MAX_PAYLOAD + 1);

    state_t           state, state_next;
    logic [4:0]       hdr_idx;
    logic [CNT_W-1:0] pay_cnt, pay_cnt_inc, target;
    logic             len_mode;
    logic [15:0]      tl_next;
    logic             at_type_end;
    logic             tlv_next, psv_next, ferr_next;
`ifdef ETH_VLAN_EN
    logic             vlan_next;
`endif

    // Value type_length will hold once the byte now on data is shifted in.
    assign tl_next = {type_length[7:0], data};
    // Saturate at MAX_PAYLOAD+1 so an oversized payload can never wrap.
    assign pay_cnt_inc = (pay_cnt == CNT_OVF) ? pay_cnt : pay_cnt + CNT_W'(1);

    assign enable_header  = control & ((state == IDLE) | (state == DST) |
                                       (state == SRC)  | (state == TYPE));
    assign enable_payload = control & (state == PAYLOAD);

    always_comb begin
`ifdef ETH_VLAN_EN
        // A 0x8100 tag defers classification to the inner type at byte 17.
        at_type_end = ((hdr_idx == 5'd13) && (tl_next != 16'h8100)) ||
                      (hdr_idx == 5'd17);
`else
        at_type_end = (hdr_idx == 5'd13);
`endif
    end

    always_comb begin
        state_next = state;
        tlv_next   = 1'b0;
        psv_next   = 1'b0;
        ferr_next  = 1'b0;
`ifdef ETH_VLAN_EN
        vlan_next  = 1'b0;
`endif
        case (state)
            SYNC: if (!control) state_next = IDLE;
            IDLE: if (control) state_next = DST;
            DST: begin
                if (!control) begin
                    ferr_next  = 1'b1;
                    state_next = IDLE;
                end else if (hdr_idx == 5'd5) begin
                    state_next = SRC;
                end
            end
            SRC: begin
                if (!control) begin
                    ferr_next  = 1'b1;
                    state_next = IDLE;
                end else if (hdr_idx == 5'd11) begin
                    state_next = TYPE;
                end
            end
            TYPE: begin
                if (!control) begin
                    ferr_next  = 1'b1;
                    state_next = IDLE;
                end else if (at_type_end) begin
                    if ((tl_next <= MAX_TL) || (tl_next >= ETHERTYPE_MIN)) begin
                        tlv_next   = 1'b1;
                        state_next = PAYLOAD;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = DONE;
                    end
                end
`ifdef ETH_VLAN_EN
                else if (hdr_idx == 5'd15) begin
                    vlan_next = 1'b1;
                end
`endif
            end
            PAYLOAD: begin
                if (!control) begin
                    // Length mode always ends in DONE at the target, so a drop
                    // here in length mode is a truncated payload.
                    if (!len_mode && (pay_cnt >= CNT_MIN) && (pay_cnt <= CNT_MAX))
                        psv_next = 1'b1;
                    else
                        ferr_next = 1'b1;
                    state_next = IDLE;
                end else if (len_mode) begin
                    if (pay_cnt_inc == target) begin
                        psv_next   = 1'b1;
                        state_next = DONE;
                    end
                end else if (pay_cnt_inc == CNT_OVF) begin
                    ferr_next  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: if (!control) state_next = IDLE;
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= SYNC;
            hdr_idx           <= '0;
            pay_cnt           <= '0;
            target            <= '0;
            len_mode          <= 1'b0;
            dst_mac           <= '0;
            src_mac           <= '0;
            type_length       <= '0;
            type_length_valid <= 1'b0;
            packet_size_valid <= 1'b0;
            frame_error       <= 1'b0;
`ifdef ETH_VLAN_EN
            vlan_tci          <= '0;
            vlan_valid        <= 1'b0;
`endif
        end else begin
            state             <= state_next;
            type_length_valid <= tlv_next;
            packet_size_valid <= psv_next;
            frame_error       <= ferr_next;
`ifdef ETH_VLAN_EN
            vlan_valid        <= vlan_next;
`endif
            // The byte taken in IDLE is header byte 0.
            if (control && (state == IDLE))
                hdr_idx <= 5'd1;
            else if (control && ((state == DST) || (state == SRC) || (state == TYPE)))
                hdr_idx <= hdr_idx + 5'd1;

            if (control && ((state == IDLE) || (state == DST)))
                dst_mac <= {dst_mac[39:0], data};
            if (control && (state == SRC))
                src_mac <= {src_mac[39:0], data};
            if (control && (state == TYPE)) begin
`ifdef ETH_VLAN_EN
                if ((hdr_idx == 5'd14) || (hdr_idx == 5'd15))
                    vlan_tci <= {vlan_tci[7:0], data};
                else
                    type_length <= tl_next;
`else
                type_length <= tl_next;
`endif
            end

            if (control && (state == TYPE) && at_type_end) begin
                len_mode <= (tl_next <= MAX_TL);
                target   <= (tl_next < MIN_TL) ? CNT_MIN : CNT_W'(tl_next);
            end

            if (state == PAYLOAD) begin
                if (control) pay_cnt <= pay_cnt_inc;
            end else begin
                pay_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_eth_header_sequencer.sv
// tb_eth_header_sequencer
//   Self-checking bench for eth_header_sequencer. Expected pulses are queued
//   with the cycle in which they must appear; a negedge monitor pops and
//   compares them against the observed pulse outputs every cycle.
module tb_eth_header_sequencer;

    logic        clock;
    logic        reset;
    logic        control;
    logic [7:0]  data;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] type_length;
    logic        type_length_valid;
    logic        packet_size_valid;
    logic        frame_error;
    logic        enable_header;
    logic        enable_payload;
`ifdef ETH_VLAN_EN
    logic [15:0] vlan_tci;
    logic        vlan_valid;
`endif

    eth_header_sequencer #(
        .MIN_PAYLOAD(46),
        .MAX_PAYLOAD(1500),
        .CNT_W(11)
    ) dut (
        .clock(clock),
        .reset(reset),
        .control(control),
        .data(data),
        .dst_mac(dst_mac),
        .src_mac(src_mac),
        .type_length(type_length),
        .type_length_valid(type_length_valid),
        .packet_size_valid(packet_size_valid),
        .frame_error(frame_error),
`ifdef ETH_VLAN_EN
        .vlan_tci(vlan_tci),
        .vlan_valid(vlan_valid),
`endif
        .enable_header(enable_header),
        .enable_payload(enable_payload)
    );

    localparam logic [2:0] TLV  = 3'b001;
    localparam logic [2:0] PSV  = 3'b010;
    localparam logic [2:0] FERR = 3'b100;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  mask;
    } exp_t;

    exp_t        sb[$];
    int unsigned neg_cnt  = 0;
    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [2:0]  exp_m;
    logic [2:0]  obs_m;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard monitor: every queued pulse must appear in exactly its cycle,
    // and no pulse may appear that was not queued.
    always @(negedge clock) begin
        neg_cnt = neg_cnt + 1;
        exp_m = 3'b000;
        while (sb.size() > 0 && sb[0].cyc <= neg_cnt) begin
            exp_m = exp_m | sb[0].mask;
            void'(sb.pop_front());
        end
        obs_m = {frame_error, packet_size_valid, type_length_valid};
        if (obs_m != 3'b000 || exp_m != 3'b000) begin
            checks = checks + 1;
            if (obs_m !== exp_m) begin
                failures = failures + 1;
                $display("FAIL pulses cycle=%0d observed(ferr,psv,tlv)=%b required=%b",
                         neg_cnt, obs_m, exp_m);
            end
        end
    end

    // The byte driven now is sampled at the next posedge; any pulse it causes
    // is visible at the negedge that follows.
    task automatic expect_pulse(input logic [2:0] m);
        exp_t e;
        e.cyc  = neg_cnt + 1;
        e.mask = m;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        control = 1'b1;
        data    = b;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycle();
        control = 1'b0;
        data    = 8'h00;
        @(posedge clock);
        #1;
    endtask

    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++) send_byte(8'(i + 8'h30));
    endtask

    task automatic send_header(input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] tl);
        for (int i = 0; i < 6; i++) begin
            send_byte(d[47 - 8*i -: 8]);
            if (i == 0) begin
                checks = checks + 1;
                if (enable_header !== 1'b1) begin
                    failures = failures + 1;
                    $display("FAIL hdr_enable observed=%b required=1", enable_header);
                end
            end
        end
        for (int i = 0; i < 6; i++) send_byte(s[47 - 8*i -: 8]);
        send_byte(tl[15:8]);
        send_byte(tl[7:0]);
        if (tl <= 16'd1500 || tl >= 16'h0600) expect_pulse(TLV);
        else expect_pulse(FERR);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        control = 1'b0;
        data    = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        checks = checks + 1;
        if ({dst_mac, src_mac, type_length} !== 112'h0) begin
            failures = failures + 1;
            $display("FAIL reset_fields observed=%h/%h/%h required=0", dst_mac, src_mac, type_length);
        end
        checks = checks + 1;
        if ({type_length_valid, packet_size_valid, frame_error, enable_header, enable_payload} !== 5'b0) begin
            failures = failures + 1;
            $display("FAIL reset_flags observed=%b required=00000",
                     {type_length_valid, packet_size_valid, frame_error, enable_header, enable_payload});
        end
        reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_length_frame();
        send_header(48'h001122334455, 48'h66778899AABB, 16'h0040);
        checks = checks + 1;
        if (dst_mac !== 48'h001122334455) begin
            failures = failures + 1;
            $display("FAIL len_dst observed=%h required=001122334455", dst_mac);
        end
        checks = checks + 1;
        if (src_mac !== 48'h66778899AABB) begin
            failures = failures + 1;
            $display("FAIL len_src observed=%h required=66778899aabb", src_mac);
        end
        checks = checks + 1;
        if (type_length !== 16'h0040) begin
            failures = failures + 1;
            $display("FAIL len_type observed=%h required=0040", type_length);
        end
        checks = checks + 1;
        if ({enable_header, enable_payload} !== 2'b01) begin
            failures = failures + 1;
            $display("FAIL len_enables observed=%b required=01", {enable_header, enable_payload});
        end
        send_payload(64);
        expect_pulse(PSV);
        send_payload(4);
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_short_padded();
        send_header(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h0010);
        send_payload(46);
        expect_pulse(PSV);
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_ethertype();
        send_header(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800);
        send_payload(100);
        idle_cycle();
        expect_pulse(PSV);
        send_header(48'h010203040506, 48'h0708090A0B0C, 16'h0800);
        send_payload(20);
        idle_cycle();
        expect_pulse(FERR);
        idle_cycle();
    endtask

    task automatic test_illegal_type();
        send_header(48'h112233445566, 48'h778899AABBCC, 16'h05E0);
        checks = checks + 1;
        if ({enable_header, enable_payload} !== 2'b00) begin
            failures = failures + 1;
            $display("FAIL illegal_enables observed=%b required=00", {enable_header, enable_payload});
        end
        send_payload(10);
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_reset_mid_frame();
        send_header(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800);
        send_payload(29);
        reset = 1'b1;
        send_byte(8'h55);
        reset = 1'b0;
        checks = checks + 1;
        if ({dst_mac, src_mac, type_length} !== 112'h0) begin
            failures = failures + 1;
            $display("FAIL midreset_fields observed=%h/%h/%h required=0", dst_mac, src_mac, type_length);
        end
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(8'hC0 + i));
            checks = checks + 1;
            if ({enable_header, enable_payload, dst_mac} !== 50'h0) begin
                failures = failures + 1;
                $display("FAIL midreset_drop byte=%0d observed en=%b dst=%h required=0",
                         i, {enable_header, enable_payload}, dst_mac);
            end
        end
        idle_cycle();
        send_header(48'hC0FFEE000001, 48'hC0FFEE000002, 16'h002E);
        send_payload(46);
        expect_pulse(PSV);
        checks = checks + 1;
        if (dst_mac !== 48'hC0FFEE000001) begin
            failures = failures + 1;
            $display("FAIL midreset_next_dst observed=%h required=c0ffee000001", dst_mac);
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_truncation();
        logic [47:0] d;
        d = 48'hDEADBEEF0102;
        for (int i = 0; i < 6; i++) send_byte(d[47 - 8*i -: 8]);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i));
        idle_cycle();
        expect_pulse(FERR);
        send_header(48'h5A5A5A5A5A5A, 48'h3C3C3C3C3C3C, 16'h0030);
        send_payload(48);
        expect_pulse(PSV);
        checks = checks + 1;
        if (src_mac !== 48'h3C3C3C3C3C3C) begin
            failures = failures + 1;
            $display("FAIL trunc_next_src observed=%h required=3c3c3c3c3c3c", src_mac);
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_size_boundaries();
        send_header(48'h1, 48'h2, 16'h0600);
        send_payload(46);
        idle_cycle();
        expect_pulse(PSV);
        send_header(48'h3, 48'h4, 16'h0600);
        send_payload(45);
        idle_cycle();
        expect_pulse(FERR);
        send_header(48'h5, 48'h6, 16'h86DD);
        send_payload(1500);
        idle_cycle();
        expect_pulse(PSV);
        send_header(48'h7, 48'h8, 16'h86DD);
        send_payload(1501);
        expect_pulse(FERR);
        send_payload(3);
        idle_cycle();
        send_header(48'h9, 48'hA, 16'h05DC);
        send_payload(1500);
        expect_pulse(PSV);
        idle_cycle();
        send_header(48'hB, 48'hC, 16'h05DD);
        send_payload(2);
        idle_cycle();
        send_header(48'hD, 48'hE, 16'h0000);
        send_payload(46);
        expect_pulse(PSV);
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        send_header(48'h0000AAAA0001, 48'h0000BBBB0001, 16'h0800);
        send_payload(60);
        idle_cycle();
        expect_pulse(PSV);
        send_header(48'h0000AAAA0002, 48'h0000BBBB0002, 16'h0806);
        checks = checks + 1;
        if (dst_mac !== 48'h0000AAAA0002) begin
            failures = failures + 1;
            $display("FAIL b2b_dst observed=%h required=0000aaaa0002", dst_mac);
        end
        send_payload(60);
        idle_cycle();
        expect_pulse(PSV);
        idle_cycle();
    endtask

    initial begin
        reset   = 1'b1;
        control = 1'b0;
        data    = 8'h00;
        test_reset();
        test_length_frame();
        test_short_padded();
        test_ethertype();
        test_illegal_type();
        test_reset_mid_frame();
        test_truncation();
        test_size_boundaries();
        test_back_to_back();
        repeat (2) @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_header_sequencer.md
Name: eth_header_sequencer

Overview:
Byte-level sequencer for the Ethernet packet detector datapath. It follows a framed byte stream (control/data), walks the header fields by byte count, captures the destination MAC, source MAC and type/length, and emits the valid strobes plus the header/payload enables that drive the header and payload modules. It also checks payload size against the type/length field and flags malformed frames.

Parameters:
MIN_PAYLOAD  46    minimum payload bytes; shorter length-mode frames are counted as padded up to this value
MAX_PAYLOAD  1500  maximum payload bytes; also the upper bound of the length interpretation
CNT_W        11    payload byte counter width; must hold MAX_PAYLOAD+1

Ports:
clock             in   1   clock; all state changes on the rising edge
reset             in   1   synchronous, active-high reset
control           in   1   frame valid; high while frame bytes are present, one byte per cycle
data              in   8   frame byte; sampled only when control=1
dst_mac           out  48  captured destination MAC; first byte in [47:40]
src_mac           out  48  captured source MAC; first byte in [47:40]
type_length       out  16  captured type/length; first byte in [15:8]
type_length_valid out  1   one-cycle pulse when type_length is complete and legal
packet_size_valid out  1   one-cycle pulse when the payload size check passes
frame_error       out  1   one-cycle pulse on any framing or size violation
enable_header     out  1   level; header module enable
enable_payload    out  1   level; payload module enable

Behaviour:
- States: SYNC, IDLE, DST, SRC, TYPE, PAYLOAD, DONE.
- Reset: state=SYNC, payload counter=0, all field registers=0, all pulses=0.
- SYNC: waits for control=0, then goes to IDLE. A frame already in progress is never parsed.
- IDLE, control=1: the byte is dst byte 0; go to DST. Header byte index runs 0..13 (dst 0-5, src 6-11, type 12-13).
- dst_mac, src_mac and type_length shift in MSB-first as each byte is sampled.
- Each field completes when its last byte is sampled on a rising edge:
  - dst byte 5: DST->SRC.
  - src byte 11: SRC->TYPE.
  - type byte 13: classify the value, then TYPE->PAYLOAD.
- type_length classes:
  - <=MAX_PAYLOAD: length mode.
  - >=0x0600: ethertype mode.
  - 1501..1535: illegal; frame_error pulse, go to DONE.
- type_length_valid pulses for one cycle, registered, in the cycle after byte 13 is sampled, and only when the value is legal.
- PAYLOAD counts sampled bytes; the first payload byte gives count 1.
  - Length mode: target = max(length, MIN_PAYLOAD). When count reaches target, pulse packet_size_valid (next cycle) and go to DONE. Trailing bytes (FCS, etc.) are ignored in DONE.
  - Ethertype mode: counts until control=0. If MIN_PAYLOAD<=count<=MAX_PAYLOAD, pulse packet_size_valid; otherwise pulse frame_error. Either way go to IDLE.
  - Length mode: count>MAX_PAYLOAD cannot occur. In ethertype mode, a count reaching MAX_PAYLOAD+1 goes to DONE immediately with frame_error; the counter saturates and never wraps.
- control=0 in DST, SRC, TYPE, or in PAYLOAD in length mode before target: frame_error pulse, go to IDLE.
- DONE: go to IDLE when control=0.
- Back-to-back frames: control must be low for at least one cycle between frames. In IDLE, a cycle with control=1 always starts a new frame.
- enable_header = control & (state in IDLE, DST, SRC, TYPE). This is combinational from registered state.
- enable_payload = control & (state==PAYLOAD).
- Reset asserted mid-frame: next edge gives the reset values; the rest of the frame is dropped via SYNC.
- packet_size_valid and frame_error are never high in the same cycle.

Optional Feature:
- Macro ETH_VLAN_EN.
- Defined:
  - If type_length==0x8100 at byte 13, type_length_valid is not pulsed.
  - Bytes 14-15 are captured into an extra output vlan_tci[15:0] (MSB-first) and pulse vlan_valid.
  - Bytes 16-17 re-capture type_length; classification, the type_length_valid pulse and the payload rules then apply from byte 18.
  - enable_header stays high through byte 17.
- Undefined: 0x8100 is treated as an ordinary ethertype, and the vlan_tci/vlan_valid ports do not exist.

Test Plan:
- Length frame: 14 header bytes (dst 00:11:22:33:44:55, src 66:77:88:99:AA:BB, type 0x0040), then 64 payload bytes, then 4 FCS bytes. Required: dst_mac=0x001122334455, src_mac=0x66778899AABB, type_length_valid pulse in the cycle after byte 13, packet_size_valid after payload byte 64, no frame_error.
- Short padded frame: length 0x0010 with 46 payload bytes. Required: packet_size_valid after byte 46, not after byte 16.
- Ethertype 0x0800 with 100 payload bytes, then control low. Required: packet_size_valid in the cycle after the drop. Repeat with 20 bytes: frame_error, no packet_size_valid.
- Illegal type 0x05E0. Required: no type_length_valid, frame_error pulse, remaining bytes ignored until control low.
- Reset asserted at payload byte 30, control held high for 10 more cycles. Required: all outputs 0 and enables low until control drops; the next frame parses correctly.
- Truncation: control drops after byte 9. Required: frame_error pulse, state IDLE, next frame parses correctly.
